// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if: CPU, SRAM and memory-side signals of the data cache controller.
// The master modport is the controller's view; slave is the surrounding system.
interface dcache_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  localparam int TAG_W = ADDR_W - 9;

  // CPU side
  logic                cpu_req_i;
  logic                cpu_write_i;
  logic [ADDR_W-1:0]   cpu_addr_i;
  logic [31:0]         cpu_data_i;
  logic [31:0]         cpu_data_o;
  logic                cpu_stall_o;

  // SRAM side
  logic                sram_enable_o;
  logic                sram_write_o;
  logic [3:0]          sram_addr_o;
  logic [TAG_W+1:0]    sram_tag_o;
  logic [LINE_W-1:0]   sram_data_o;
  logic [TAG_W+1:0]    sram_tag_i;
  logic [LINE_W-1:0]   sram_data_i;
  logic                sram_hit_i;

  // Main memory side
  logic                mem_enable_o;
  logic                mem_write_o;
  logic [ADDR_W-1:0]   mem_addr_o;
  logic [LINE_W-1:0]   mem_data_o;
  logic [LINE_W-1:0]   mem_data_i;
  logic                mem_ack_i;

  modport master (
    input  cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i,
    output cpu_data_o, cpu_stall_o,
    output sram_enable_o, sram_write_o, sram_addr_o, sram_tag_o, sram_data_o,
    input  sram_tag_i, sram_data_i, sram_hit_i,
    output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    input  mem_data_i, mem_ack_i
  );

  modport slave (
    output cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i,
    input  cpu_data_o, cpu_stall_o,
    input  sram_enable_o, sram_write_o, sram_addr_o, sram_tag_o, sram_data_o,
    output sram_tag_i, sram_data_i, sram_hit_i,
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    output mem_data_i, mem_ack_i
  );
endinterface

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: sequencing controller for the 16-set, 2-way, 256-bit-line data cache.
// Hits are served in zero wait states; misses write back a dirty victim, refill
// the line from memory and let the held CPU request retry and hit.
// Optional feature macro: DCACHE_PERF_CNT_EN adds hit_cnt_o / miss_cnt_o counters.
module dcache_ctrl #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic          clk_i,
  input  logic          rst_i,
  dcache_ctrl_if.master bus
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]   hit_cnt_o,
  output logic [31:0]   miss_cnt_o
`endif
);
  localparam int TAG_W = ADDR_W - 9;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    REFILL    = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_nextState;

  // Miss context captured in the detect cycle; r_reqLine holds addr[ADDR_W-1:5]
  logic [TAG_W-1:0]    r_victimTag;
  logic [LINE_W-1:0]   r_victimLine;
  logic [ADDR_W-6:0]   r_reqLine;
  logic [LINE_W-1:0]   r_refillLine;

  logic [TAG_W-1:0]    w_reqTag;
  logic [3:0]          w_index;
  logic [7:0]          w_wordOffset;
  logic                w_access;
  logic                w_hit;
  logic                w_miss;
  logic                w_victimValid;
  logic                w_victimDirty;
  logic [LINE_W-1:0]   w_mergedLine;

  assign w_reqTag      = bus.cpu_addr_i[ADDR_W-1:9];
  assign w_index       = bus.cpu_addr_i[8:5];
  assign w_wordOffset  = {bus.cpu_addr_i[4:2], 5'b0};
  assign w_access      = (r_state == IDLE) && bus.cpu_req_i;
  assign w_hit         = w_access && bus.sram_hit_i;
  assign w_miss        = w_access && !bus.sram_hit_i;
  assign w_victimValid = bus.sram_tag_i[TAG_W+1];
  assign w_victimDirty = bus.sram_tag_i[TAG_W];

  // Store merge: the hit line with the addressed word replaced by the CPU data
  always_comb begin
    w_mergedLine = bus.sram_data_i;
    w_mergedLine[w_wordOffset +: 32] = bus.cpu_data_i;
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // Capture victim and request on a miss, and the refill line on the read ack
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_victimTag  <= '0;
      r_victimLine <= '0;
      r_reqLine    <= '0;
      r_refillLine <= '0;
    end else begin
      if (w_miss) begin
        r_victimTag  <= bus.sram_tag_i[TAG_W-1:0];
        r_victimLine <= bus.sram_data_i;
        r_reqLine    <= bus.cpu_addr_i[ADDR_W-1:5];
      end
      if ((r_state == ALLOCATE) && bus.mem_ack_i) r_refillLine <= bus.mem_data_i;
    end
  end

  // Next-state decode and all outputs; everything idles low unless a state drives it
  always_comb begin
    w_nextState       = r_state;
    bus.cpu_data_o    = '0;
    bus.cpu_stall_o   = 1'b0;
    bus.sram_enable_o = 1'b0;
    bus.sram_write_o  = 1'b0;
    bus.sram_addr_o   = '0;
    bus.sram_tag_o    = '0;
    bus.sram_data_o   = '0;
    bus.mem_enable_o  = 1'b0;
    bus.mem_write_o   = 1'b0;
    bus.mem_addr_o    = '0;
    bus.mem_data_o    = '0;
    case (r_state)
      IDLE: begin
        bus.sram_enable_o = bus.cpu_req_i;
        if (bus.cpu_req_i) bus.sram_addr_o = w_index;
        if (w_hit) begin
          if (bus.cpu_write_i) begin
            bus.sram_write_o = 1'b1;
            bus.sram_tag_o   = {2'b11, w_reqTag};
            bus.sram_data_o  = w_mergedLine;
          end else begin
            bus.cpu_data_o = bus.sram_data_i[w_wordOffset +: 32];
          end
        end else if (w_miss) begin
          bus.cpu_stall_o = 1'b1;
          w_nextState = (w_victimValid && w_victimDirty) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        bus.cpu_stall_o  = 1'b1;
        bus.mem_enable_o = 1'b1;
        bus.mem_write_o  = 1'b1;
        bus.mem_addr_o   = {r_victimTag, r_reqLine[3:0], 5'b0};
        bus.mem_data_o   = r_victimLine;
        if (bus.mem_ack_i) w_nextState = ALLOCATE;
      end
      ALLOCATE: begin
        bus.cpu_stall_o  = 1'b1;
        bus.mem_enable_o = 1'b1;
        bus.mem_addr_o   = {r_reqLine, 5'b0};
        if (bus.mem_ack_i) w_nextState = REFILL;
      end
      REFILL: begin
        bus.cpu_stall_o   = 1'b1;
        bus.sram_enable_o = 1'b1;
        bus.sram_write_o  = 1'b1;
        bus.sram_addr_o   = r_reqLine[3:0];
        bus.sram_tag_o    = {2'b10, r_reqLine[ADDR_W-6:4]};
        bus.sram_data_o   = r_refillLine;
        w_nextState       = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

`ifdef DCACHE_PERF_CNT_EN
  logic        r_retry;
  logic [31:0] r_hitCnt;
  logic [31:0] r_missCnt;

  // Count CPU-visible hits and misses; the hit that retries a refilled access is skipped
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_retry   <= 1'b0;
      r_hitCnt  <= '0;
      r_missCnt <= '0;
    end else begin
      r_retry <= (r_state == REFILL);
      if (w_hit && !r_retry) r_hitCnt <= r_hitCnt + 32'd1;
      if (w_miss)            r_missCnt <= r_missCnt + 32'd1;
    end
  end

  assign hit_cnt_o  = r_hitCnt;
  assign miss_cnt_o = r_missCnt;
`endif
endmodule
